// File: rtl/lfsr_seq_ctrl.sv
// Job controller for a reconfigurable LFSR: loads the seed, runs the LFSR and packs its serial output into words.
// Optional feature: define LFSR_CTRL_CONF_CHECK_EN to reject out-of-range configuration indices via err_o.
module lfsr_seq_ctrl #(
  parameter int             N    = 3,
  parameter int             C    = 2,
  parameter int             W    = 8,
  parameter int             L    = 8,
  parameter logic [N-1:0]   SEED = '1,
  parameter int             CW   = (C > 1) ? $clog2(C) : 1
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [CW-1:0] req_conf_i,
  input  logic [L-1:0]  req_words_i,
  output logic          word_valid_o,
  input  logic          word_ready_i,
  output logic [W-1:0]  word_data_o,
  output logic          word_last_o,
  output logic          busy_o,
`ifdef LFSR_CTRL_CONF_CHECK_EN
  output logic          err_o,
`endif
  output logic          lfsr_seq_ld_en_o,
  output logic [N-1:0]  lfsr_seq_o,
  output logic [C-1:0]  lfsr_conf_sel_o,
  output logic          lfsr_run_en_o,
  input  logic          lfsr_outp_i
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

  state_t         state;
  logic [L-1:0]   words_left;
  logic [BW-1:0]  bitcnt;
  logic           conf_ok;

  // Out-of-range indices fall back to configuration 0.
  function automatic logic [C-1:0] onehot(input logic [CW-1:0] idx);
    logic [C-1:0] v;
    v = '0;
    for (int i = 0; i < C; i++) begin
      if (int'(idx) == i) v[i] = 1'b1;
    end
    if (v == '0) v[0] = 1'b1;
    return v;
  endfunction

`ifdef LFSR_CTRL_CONF_CHECK_EN
  assign conf_ok = (int'(req_conf_i) < C);
`else
  assign conf_ok = 1'b1;
`endif

  assign lfsr_seq_o = SEED;

  // NOTE: every output is assigned on the transition into its state, so all of them come
  // straight from flops; non-blocking assignments keep each update in step with the state.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state            <= IDLE;
      req_ready_o      <= 1'b1;
      busy_o           <= 1'b0;
      word_valid_o     <= 1'b0;
      word_last_o      <= 1'b0;
      word_data_o      <= '0;
      lfsr_seq_ld_en_o <= 1'b0;
      lfsr_run_en_o    <= 1'b0;
      lfsr_conf_sel_o  <= C'(1);
      words_left       <= '0;
      bitcnt           <= '0;
`ifdef LFSR_CTRL_CONF_CHECK_EN
      err_o            <= 1'b0;
`endif
    end else begin
`ifdef LFSR_CTRL_CONF_CHECK_EN
      err_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid_i && conf_ok) begin
            words_left       <= req_words_i;
            lfsr_conf_sel_o  <= onehot(req_conf_i);
            state            <= LOAD;
            req_ready_o      <= 1'b0;
            busy_o           <= 1'b1;
            lfsr_seq_ld_en_o <= 1'b1;
          end
`ifdef LFSR_CTRL_CONF_CHECK_EN
          else if (req_valid_i) begin
            err_o <= 1'b1;
          end
`endif
        end
        LOAD: begin
          lfsr_seq_ld_en_o <= 1'b0;
          bitcnt           <= '0;
          word_data_o      <= '0;
          if (words_left == '0) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else begin
            state         <= RUN;
            lfsr_run_en_o <= 1'b1;
          end
        end
        RUN: begin
          word_data_o[bitcnt] <= lfsr_outp_i;
          if (bitcnt == BW'(W - 1)) begin
            // Freeze the LFSR while the word waits so stalls do not skip sequence bits.
            state         <= HOLD;
            lfsr_run_en_o <= 1'b0;
            word_valid_o  <= 1'b1;
            word_last_o   <= (words_left == L'(1));
          end else begin
            bitcnt <= bitcnt + 1'b1;
          end
        end
        HOLD: begin
          if (word_ready_i) begin
            word_valid_o <= 1'b0;
            word_last_o  <= 1'b0;
            words_left   <= words_left - 1'b1;
            bitcnt       <= '0;
            if (words_left == L'(1)) begin
              state       <= IDLE;
              req_ready_o <= 1'b1;
              busy_o      <= 1'b0;
            end else begin
              state         <= RUN;
              lfsr_run_en_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with a small 3-bit two-configuration LFSR attached to its control pins.
// Under LFSR_CTRL_CONF_CHECK_EN the out-of-range request raises err_o instead of running configuration 0.
module tb_lfsr_seq_ctrl;

  localparam int N  = 3;
  localparam int C  = 2;
  localparam int W  = 4;
  localparam int L  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_conf;
  logic [L-1:0]  req_words;
  logic          word_valid;
  logic          word_ready;
  logic [W-1:0]  word_data;
  logic          word_last;
  logic          busy;
  logic          err;
  logic          ld;
  logic [N-1:0]  seq;
  logic [C-1:0]  sel;
  logic          run;
  logic          outp;
  logic [N-1:0]  lfsr;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ld_cnt = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  lfsr_seq_ctrl #(.N(N), .C(C), .W(W), .L(L), .SEED(3'b111), .CW(CW)) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_conf_i       (req_conf),
    .req_words_i      (req_words),
    .word_valid_o     (word_valid),
    .word_ready_i     (word_ready),
    .word_data_o      (word_data),
    .word_last_o      (word_last),
    .busy_o           (busy),
`ifdef LFSR_CTRL_CONF_CHECK_EN
    .err_o            (err),
`endif
    .lfsr_seq_ld_en_o (ld),
    .lfsr_seq_o       (seq),
    .lfsr_conf_sel_o  (sel),
    .lfsr_run_en_o    (run),
    .lfsr_outp_i      (outp)
  );

`ifndef LFSR_CTRL_CONF_CHECK_EN
  assign err = 1'b0;
`endif

  // conf 0: a[k+3] = a[k] ^ a[k+1]; conf 1: a[k+3] = a[k] ^ a[k+2]; output is the LSB.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)  lfsr <= 3'b111;
    else if (ld)  lfsr <= seq;
    else if (run) lfsr <= {sel[1] ? (lfsr[0] ^ lfsr[2]) : (lfsr[0] ^ lfsr[1]), lfsr[2:1]};
  end
  assign outp = lfsr[0];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ld && run) overlap <= overlap + 1;
    if (ld) ld_cnt <= ld_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset_values();
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_word_valid", word_valid, 0);
    check("rst_word_last", word_last, 0);
    check("rst_word_data", word_data, 0);
    check("rst_ld_en", ld, 0);
    check("rst_run_en", run, 0);
    check("rst_conf_sel", sel, 2'b01);
    check("rst_seq", seq, 3'b111);
    check("rst_err", err, 0);
  endtask

  // Runs one job; exp_w packs expected words with word 0 in the low nibble.
  task automatic do_job(input logic [CW-1:0] conf, input int nwords, input logic [11:0] exp_w,
                        input logic [C-1:0] exp_sel, input int stall_idx);
    int t0, due, n, ld_base;
    logic [W-1:0] ew;
    ld_base = ld_cnt;
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_conf  = conf;
    req_words = L'(nwords);
    t0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("busy_load", busy, 1);
    check("ld_en_load", ld, 1);
    check("run_en_load", run, 0);
    check("conf_sel", sel, exp_sel);
    check("req_ready_busy", req_ready, 0);
    due = t0 + 2 + W;
    for (int i = 0; i < nwords; i++) begin
      n = 0;
      while (!word_valid && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      check("word_timeout", word_valid, 1);
      check("word_cycle", cyc, due);
      ew = exp_w[i*4 +: 4];
      check("word_data", word_data, ew);
      check("word_last", word_last, (i == nwords - 1));
      if (i == stall_idx) begin
        word_ready = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          check("stall_valid", word_valid, 1);
          check("stall_data", word_data, ew);
          check("stall_last", word_last, (i == nwords - 1));
          check("stall_run_en", run, 0);
        end
        word_ready = 1'b1;
      end
      due = cyc + W + 1;
      @(posedge clk); #1;
    end
    if (nwords == 0) begin
      @(posedge clk); #1;
    end
    check("done_busy", busy, 0);
    check("done_req_ready", req_ready, 1);
    check("done_word_valid", word_valid, 0);
    check("ld_en_pulses", ld_cnt - ld_base, 1);
  endtask

  initial begin
    arst_n     = 1'b0;
    req_valid  = 1'b0;
    req_conf   = '0;
    req_words  = '0;
    word_ready = 1'b1;
    #12;
    check_reset_values();
    #10 arst_n = 1'b1;
    @(posedge clk); #1;

    do_job(2'd1, 2, 12'h097, 2'b10, -1);
    do_job(2'd1, 2, 12'h097, 2'b10, 0);
    do_job(2'd0, 0, 12'h000, 2'b01, -1);
    do_job(2'd0, 3, 12'h3A7, 2'b01, -1);
    do_job(2'd1, 2, 12'h097, 2'b10, -1);

`ifdef LFSR_CTRL_CONF_CHECK_EN
    req_valid = 1'b1;
    req_conf  = 2'd3;
    req_words = 8'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("err_pulse", err, 1);
    check("err_no_load", ld, 0);
    check("err_busy", busy, 0);
    check("err_sel_kept", sel, 2'b10);
    check("err_req_ready", req_ready, 1);
    @(posedge clk); #1;
    check("err_one_cycle", err, 0);
    check("err_no_word", word_valid, 0);
`else
    do_job(2'd3, 1, 12'h007, 2'b01, -1);
`endif

    // Reset while RUN is part-way through a word.
    req_valid = 1'b1;
    req_conf  = 2'd1;
    req_words = 8'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_run_en", run, 1);
    #2 arst_n = 1'b0;
    #1;
    check_reset_values();
    #3 arst_n = 1'b1;
    @(posedge clk); #1;
    do_job(2'd1, 2, 12'h097, 2'b10, -1);

    check("ld_run_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
